// File: rtl/pueo_trig_rx.sv
// TURF trigger word receiver: phase-locked window capture, framing and sequence
// checks, trigger FIFO with an AXI4-Stream master output, error/overflow status.
module pueo_trig_rx #(
  parameter int PHASE_OFFSET = 3,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic        sysclk_i,
  input  logic        sysclk_rst_i,
  input  logic        sysclk_phase_i,
  input  logic [11:0] turf_trig_i,
  input  logic [7:0]  turf_metadata_i,
  input  logic        turf_valid_i,
  output logic [19:0] m_trig_tdata,
  output logic        m_trig_tvalid,
  input  logic        m_trig_tready,
  output logic        locked_o,
  output logic        seq_err_o,
  output logic        frame_err_o,
  output logic        overflow_o,
  output logic [15:0] err_count_o,
  input  logic        clr_i
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [2:0] WIN_FIRST = 3'(PHASE_OFFSET);
  localparam logic [2:0] WIN_LAST  = 3'(PHASE_OFFSET + 3);

  logic [2:0]  pc_q, pc_d;
  logic        locked_q, locked_d;
  logic        pend_q, pend_d, samp_q, samp_d, bad_q, bad_d;
  logic [19:0] word_q, word_d;
  logic        seq_vld_q, seq_vld_d;
  logic [6:0]  exp_q, exp_d;
  logic        seq_err_q, seq_err_d, frame_err_q, frame_err_d;
  logic        overflow_q, overflow_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic        tvalid_q, tvalid_d;
  logic [19:0] mem_q [FIFO_DEPTH];

  logic [2:0]  rel;
  logic        in_win, phase_err, frame_det, seq_det, commit;
  logic        pop, full, push_ok, ovf_evt;
  logic [1:0]  n_err;
  logic [16:0] err_sum;

  always_comb begin
    pc_d        = sysclk_phase_i ? 3'd0 : pc_q + 3'd1;
    locked_d    = locked_q | sysclk_phase_i;
    pend_d      = pend_q;
    samp_d      = samp_q;
    bad_d       = bad_q;
    word_d      = word_q;
    frame_det   = 1'b0;
    commit      = 1'b0;
    rel         = pc_q - WIN_FIRST;
    in_win      = ~rel[2];
    phase_err   = sysclk_phase_i & locked_q & (pc_q != 3'd7);

    // A phase slip abandons the window outright; no framing judgement that cycle.
    if (locked_q) begin
      if (phase_err) begin
        pend_d = 1'b0;
      end else if (!in_win) begin
        frame_det = turf_valid_i;
      end else if (pc_q == WIN_FIRST) begin
        pend_d = turf_valid_i;
        samp_d = turf_valid_i;
        bad_d  = 1'b0;
        if (turf_valid_i) word_d = {turf_metadata_i, turf_trig_i};
      end else if (!bad_q && (turf_valid_i != samp_q)) begin
        frame_det = 1'b1;
        bad_d     = 1'b1;
        pend_d    = 1'b0;
      end else if (pc_q == WIN_LAST && pend_q) begin
        commit = 1'b1;
        pend_d = 1'b0;
      end
    end

    seq_det   = commit & seq_vld_q & (word_q[18:12] != exp_q);
    seq_vld_d = seq_vld_q | commit;
    exp_d     = commit ? word_q[18:12] + 7'd1 : exp_q;

    pop      = tvalid_q & m_trig_tready;
    full     = cnt_q == (AW+1)'(FIFO_DEPTH);
    push_ok  = commit & (~full | pop);
    ovf_evt  = commit & full & ~pop;
    wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, push_ok};
    rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, pop};
    cnt_d    = cnt_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
    // An entry becomes visible one cycle after it is written.
    tvalid_d = (cnt_q - {{AW{1'b0}}, pop}) != '0;

    n_err       = {1'b0, phase_err} + {1'b0, frame_det} + {1'b0, seq_det};
    err_sum     = {1'b0, (clr_i ? 16'd0 : err_cnt_q)} + {15'd0, n_err};
    err_cnt_d   = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    overflow_d  = (overflow_q & ~clr_i) | ovf_evt;
    seq_err_d   = seq_det;
    frame_err_d = frame_det;
  end

  always_ff @(posedge sysclk_i or posedge sysclk_rst_i) begin
    if (sysclk_rst_i) begin
      pc_q        <= '0;
      locked_q    <= 1'b0;
      pend_q      <= 1'b0;
      samp_q      <= 1'b0;
      bad_q       <= 1'b0;
      word_q      <= '0;
      seq_vld_q   <= 1'b0;
      exp_q       <= '0;
      seq_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      err_cnt_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      tvalid_q    <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      locked_q    <= locked_d;
      pend_q      <= pend_d;
      samp_q      <= samp_d;
      bad_q       <= bad_d;
      word_q      <= word_d;
      seq_vld_q   <= seq_vld_d;
      exp_q       <= exp_d;
      seq_err_q   <= seq_err_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      err_cnt_q   <= err_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      tvalid_q    <= tvalid_d;
    end
  end

  always_ff @(posedge sysclk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= word_q;
  end

  assign m_trig_tvalid = tvalid_q;
  assign m_trig_tdata  = tvalid_q ? mem_q[rd_ptr_q] : '0;
  assign locked_o      = locked_q;
  assign seq_err_o     = seq_err_q;
  assign frame_err_o   = frame_err_q;
  assign overflow_o    = overflow_q;
  assign err_count_o   = err_cnt_q;
endmodule

// File: tb/tb_pueo_trig_rx.sv
// Bench for pueo_trig_rx: directed scenarios plus randomized frames, checked every
// cycle against a transaction-level model of phase, window, sequence and FIFO rules.
module tb_pueo_trig_rx;
  localparam int OFF   = 3;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst, phase, valid, tready, clr;
  logic [11:0] trig;
  logic [7:0]  meta;
  logic [19:0] m_trig_tdata;
  logic        m_trig_tvalid, locked_o, seq_err_o, frame_err_o, overflow_o;
  logic [15:0] err_count_o;

  pueo_trig_rx #(.PHASE_OFFSET(OFF), .FIFO_DEPTH(DEPTH)) dut (
    .sysclk_i(clk), .sysclk_rst_i(rst), .sysclk_phase_i(phase),
    .turf_trig_i(trig), .turf_metadata_i(meta), .turf_valid_i(valid),
    .m_trig_tdata(m_trig_tdata), .m_trig_tvalid(m_trig_tvalid), .m_trig_tready(tready),
    .locked_o(locked_o), .seq_err_o(seq_err_o), .frame_err_o(frame_err_o),
    .overflow_o(overflow_o), .err_count_o(err_count_o), .clr_i(clr)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int fe_pulses = 0, se_pulses = 0;
  logic [19:0] beats[$];

  // Reference model state
  int          m_pc, cyc, m_expect, m_errs;
  bit          m_locked, m_pend, m_first, m_broken, m_seq_vld, m_ovf;
  logic [19:0] m_word;
  logic [19:0] q_data[$];
  int          q_time[$];
  bit          exp_tvalid, exp_fe, exp_se;
  logic [19:0] exp_tdata;
  bit          rand_ready, clr_next;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pc = 0; m_locked = 0; m_pend = 0; m_first = 0; m_broken = 0;
    m_seq_vld = 0; m_expect = 0; m_errs = 0; m_ovf = 0; m_word = '0;
    q_data.delete(); q_time.delete();
    exp_tvalid = 0; exp_tdata = '0; exp_fe = 0; exp_se = 0;
  endfunction

  always @(posedge clk) begin : model
    int k;
    bit pop, fe, se, perr, commit, full, ovf;
    if (rst) begin
      model_reset();
    end else begin
      pop = exp_tvalid && tready;
      fe = 0; se = 0; perr = 0; commit = 0; ovf = 0;
      k = (m_pc - OFF + 8) % 8;
      if (m_locked) begin
        if (phase && m_pc != 7) begin
          perr = 1; m_pend = 0;
        end else if (k >= 4) begin
          fe = valid;
        end else if (k == 0) begin
          m_first = valid; m_pend = valid; m_broken = 0;
          if (valid) m_word = {meta, trig};
        end else if (!m_broken && valid != m_first) begin
          fe = 1; m_broken = 1; m_pend = 0;
        end else if (k == 3 && m_pend) begin
          commit = 1; m_pend = 0;
        end
      end
      full = q_data.size() >= DEPTH;
      if (pop) begin
        void'(q_data.pop_front());
        void'(q_time.pop_front());
      end
      if (commit) begin
        if (m_seq_vld && int'(m_word[18:12]) != m_expect) se = 1;
        m_expect = (int'(m_word[18:12]) + 1) % 128;
        m_seq_vld = 1;
        if (full && !pop) ovf = 1;
        else begin
          q_data.push_back(m_word);
          q_time.push_back(cyc);
        end
      end
      if (clr) m_errs = 0;
      m_errs = m_errs + int'(perr) + int'(fe) + int'(se);
      if (m_errs > 65535) m_errs = 65535;
      m_ovf = (m_ovf && !clr) || ovf;
      if (phase) begin
        m_locked = 1; m_pc = 0;
      end else begin
        m_pc = (m_pc + 1) % 8;
      end
      cyc++;
      exp_tvalid = q_data.size() > 0 && q_time[0] + 2 <= cyc;
      exp_tdata  = exp_tvalid ? q_data[0] : '0;
      exp_fe = fe; exp_se = se;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("locked", locked_o, m_locked);
      chk("frame_err", frame_err_o, exp_fe);
      chk("seq_err", seq_err_o, exp_se);
      chk("overflow", overflow_o, m_ovf);
      chk("err_count", err_count_o, m_errs);
      chk("tvalid", m_trig_tvalid, exp_tvalid);
      if (exp_tvalid) chk("tdata", m_trig_tdata, exp_tdata);
      if (frame_err_o) fe_pulses++;
      if (seq_err_o) se_pulses++;
      if (m_trig_tvalid && tready) beats.push_back(m_trig_tdata);
    end
  end

  // Drives one 8-clock frame, ending on the cycle carrying the phase pulse.
  // mode: 0 idle, 1 good trigger, 2 valid dropped at third window cycle,
  // 3 valid at pc=0, 4 phase slip at the second window cycle.
  task automatic frame(input logic [11:0] a, input logic [7:0] md, input int mode);
    int k;
    bit done, first;
    done = 0; first = 1;
    while (!done) begin
      @(posedge clk); #1;
      k = (m_pc - OFF + 8) % 8;
      phase = (m_pc == 7);
      case (mode)
        1: valid = (k < 4);
        2: valid = (k < 2);
        3: valid = (m_pc == 0);
        4: begin valid = (k < 2); if (k == 1) phase = 1; end
        default: valid = 0;
      endcase
      trig = a; meta = md;
      clr = first && clr_next;
      first = 0;
      if (rand_ready) tready = 1'($urandom_range(0, 1));
      if (phase) done = 1;
    end
    clr_next = 0;
  endtask

  initial begin
    int base, fe0, se0, r, mode;
    logic [7:0] nm, mm;
    rst = 1; phase = 0; valid = 0; trig = '0; meta = '0; tready = 1; clr = 0;
    rand_ready = 0; clr_next = 0;
    model_reset(); cyc = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tvalid", m_trig_tvalid, 0);
    chk("rst_tdata", m_trig_tdata, 0);
    chk("rst_locked", locked_o, 0);
    chk("rst_err_count", err_count_o, 0);
    chk("rst_overflow", overflow_o, 0);
    chk("rst_pulses", {seq_err_o, frame_err_o}, 0);
    rst = 0;

    // Lock, then nominal stream
    frame(0, 0, 0);
    base = beats.size(); se0 = se_pulses; fe0 = fe_pulses;
    for (int i = 0; i < 5; i++) frame(12'h100 + 12'(i), 8'h80 + 8'(i), 1);
    chk("locked_after_pulse", locked_o, 1);
    frame(0, 0, 0); frame(0, 0, 0);
    chk("nominal_beats", beats.size() - base, 5);
    for (int i = 0; i < 5; i++) chk("nominal_data", beats[base + i], 20'h80100 + 20'(i) * 20'h01001);
    chk("nominal_err_count", err_count_o, 0);
    chk("nominal_no_pulses", (se_pulses - se0) + (fe_pulses - fe0), 0);

    // Sequence gap
    base = beats.size(); se0 = se_pulses;
    frame(12'h010, 8'h05, 1); frame(12'h011, 8'h07, 1); frame(12'h012, 8'h08, 1);
    frame(0, 0, 0); frame(0, 0, 0);
    chk("gap_seq_pulses", se_pulses - se0, 1);
    chk("gap_err_count", err_count_o, 1);
    chk("gap_beats", beats.size() - base, 3);
    chk("gap_word", beats[base + 1], 20'h07011);
    chk("gap_after", beats[base + 2], 20'h08012);

    // Framing violations
    base = beats.size(); fe0 = fe_pulses;
    frame(12'h020, 8'h09, 2); frame(0, 0, 0);
    chk("drop_frame_pulse", fe_pulses - fe0, 1);
    frame(12'h021, 8'h09, 3); frame(0, 0, 0);
    chk("early_frame_pulse", fe_pulses - fe0, 2);
    chk("framing_no_beat", beats.size() - base, 0);
    chk("framing_err_count", err_count_o, 3);

    // Backpressure and overflow
    tready = 0;
    for (int i = 0; i < 17; i++) frame(12'h200 + 12'(i), 8'h09 + 8'(i), 1);
    frame(0, 0, 0);
    chk("overflow_set", overflow_o, 1);
    chk("overflow_held", m_trig_tvalid, 1);
    base = beats.size();
    tready = 1;
    frame(0, 0, 0); frame(0, 0, 0); frame(0, 0, 0);
    chk("drain_count", beats.size() - base, 16);
    for (int i = 0; i < 16; i++) chk("drain_data", beats[base + i], {8'h09 + 8'(i), 12'h200 + 12'(i)});
    clr_next = 1;
    frame(0, 0, 0);
    chk("clr_overflow", overflow_o, 0);
    chk("clr_err_count", err_count_o, 0);

    // Phase slip with a trigger pending
    base = beats.size();
    frame(12'h300, 8'h1a, 4);
    frame(0, 0, 0);
    chk("slip_err_count", err_count_o, 1);
    chk("slip_no_beat", beats.size() - base, 0);
    frame(12'h301, 8'h1a, 1); frame(0, 0, 0);
    chk("slip_next_beat", beats.size() - base, 1);
    chk("slip_next_data", beats[base], 20'h1a301);
    chk("slip_err_stable", err_count_o, 1);

    // Reset with entries queued
    tready = 0;
    for (int i = 0; i < 3; i++) frame(12'h400 + 12'(i), 8'h1b + 8'(i), 1);
    frame(0, 0, 0);
    chk("pre_reset_tvalid", m_trig_tvalid, 1);
    #3 rst = 1;
    model_reset();
    #1;
    chk("areset_tvalid", m_trig_tvalid, 0);
    chk("areset_tdata", m_trig_tdata, 0);
    chk("areset_locked", locked_o, 0);
    chk("areset_err_count", err_count_o, 0);
    chk("areset_overflow", overflow_o, 0);
    phase = 0; valid = 0; tready = 1;
    @(posedge clk); #1;
    rst = 0;
    base = beats.size();
    repeat (10) begin
      @(posedge clk); #1;
      valid = 1; trig = 12'h4ff; meta = 8'h44;
    end
    frame(0, 0, 0);
    chk("unlocked_no_beat", beats.size() - base, 0);
    frame(12'h500, 8'h55, 1); frame(0, 0, 0);
    chk("relock_beat", beats.size() - base, 1);
    chk("relock_data", beats[base], 20'h55500);
    chk("relock_err_count", err_count_o, 0);

    // Randomized frames with random backpressure, errors and clears
    rand_ready = 1;
    nm = 8'h56;
    for (int n = 0; n < 160; n++) begin
      r = $urandom_range(0, 19);
      mode = (r < 14) ? 1 : (r < 16) ? 2 : (r < 18) ? 3 : 4;
      mm = {1'($urandom_range(0, 1)), nm[6:0]};
      if ($urandom_range(0, 7) == 0) mm[6:0] = 7'($urandom_range(0, 127));
      if (mode == 1) nm = mm + 8'd1;
      clr_next = ($urandom_range(0, 15) == 0);
      frame(12'($urandom_range(0, 4095)), mm, mode);
    end
    rand_ready = 0; tready = 1;
    frame(0, 0, 0); frame(0, 0, 0); frame(0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pueo_trig_rx.md
# pueo_trig_rx

Receiving end of the TURF trigger word interface. Consumes the phase-framed `{address, metadata, valid}` bus in the sysclk domain and checks its framing and the 7-bit metadata sequence. Accepted triggers are buffered in a small FIFO and presented on an AXI4-Stream master port for downstream readout and event building. Error and overflow status is exported for the register block.

## Interface
Parameters:
- `PHASE_OFFSET`, 3: clocks from the `sysclk_phase_i` cycle to the first cycle of the 4-clock valid window.
- `FIFO_DEPTH`, 16: trigger FIFO depth, in entries. Must be a power of 2, from 4 to 64.

Ports:
- `sysclk_i`, in, 1: system clock; the only clock.
- `sysclk_rst_i`, in, 1: reset. Asynchronous, active-high.
- `sysclk_phase_i`, in, 1: one-cycle pulse, nominally every 8 clocks.
- `turf_trig_i`, in, 12: trigger address.
- `turf_metadata_i`, in, 8: bit 7 is a flag; bits [6:0] are the sequence number.
- `turf_valid_i`, in, 1: trigger present; held for 4 clocks.
- `m_trig_tdata`, out, 20: `{metadata[7:0], addr[11:0]}`.
- `m_trig_tvalid`, out, 1: AXI4-Stream valid.
- `m_trig_tready`, in, 1: AXI4-Stream ready.
- `locked_o`, out, 1: phase lock established.
- `seq_err_o`, out, 1: one-cycle pulse on a sequence mismatch.
- `frame_err_o`, out, 1: one-cycle pulse on a framing violation.
- `overflow_o`, out, 1: sticky; a trigger was dropped because the FIFO was full.
- `err_count_o`, out, 16: saturating count of sequence, framing and phase errors.
- `clr_i`, in, 1: clears `err_count_o` and `overflow_o`.

## Operation
- **Phase counter `pc`** (3 bits):
  - Loads 0 in any cycle with `sysclk_phase_i`=1; otherwise increments, wrapping 7→0.
  - `locked_o` is set by the first phase pulse after reset.
  - A phase pulse arriving while `pc`≠7 and `locked_o`=1 is a phase error: `pc` resyncs to 0, the event increments `err_count_o`, and any trigger in flight in the current window is discarded.
- **Unlocked:** while `locked_o`=0, all bus inputs are ignored and no errors are flagged.
- **Window:** the window is `pc` = PHASE_OFFSET .. PHASE_OFFSET+3.
- **Capture:**
  - At `pc`=PHASE_OFFSET with `turf_valid_i`=1, the module registers `turf_trig_i` and `turf_metadata_i` and arms a pending trigger.
  - The trigger commits at the end of the window, at `pc`=PHASE_OFFSET+3.
- **Framing violations** (pulse `frame_err_o`, increment the count):
  - `turf_valid_i` differs from its sampled value at any later window cycle. The pending trigger is discarded.
  - `turf_valid_i`=1 outside the window. Nothing is captured.
- **Sequence check:**
  - The first committed trigger after reset or lock sets `expected` = meta[6:0]+1 (mod 128).
  - For each later trigger: if meta[6:0]≠`expected`, pulse `seq_err_o` and increment the count. In all cases the trigger is still pushed and `expected` becomes meta[6:0]+1.
  - Bit 7 is passed through unchecked.
- **FIFO:**
  - A commit pushes one entry. A commit while full drops the entry and sets `overflow_o`.
  - Pop on `m_trig_tvalid && m_trig_tready`.
  - Push and pop in the same cycle are both honoured, including when full; in that case there is no overflow.
- **AXI rule:** once `m_trig_tvalid` is asserted, it and `m_trig_tdata` hold until the transfer completes.
- **Error counter:**
  - Saturates at 0xFFFF.
  - Multiple error events in one cycle add 1 each.
  - `clr_i` together with an error sets the count to the number of new errors (clear first).
  - `clr_i` clears `overflow_o` unless an overflow occurs in the same cycle.

## Timing
- **Reset values:**
  - `pc`=0, `locked_o`=0, FIFO empty, `m_trig_tvalid`=0, `m_trig_tdata`=0.
  - `seq_err_o`=0, `frame_err_o`=0, `overflow_o`=0, `err_count_o`=0, sequence reference invalid.
- **Reset mid-operation:** the pending trigger and FIFO contents are lost; lock must be reacquired.
- **Phase pulse to `locked_o`:** `locked_o` rises in the cycle after the first phase pulse.
- **Error pulses:** `frame_err_o` and `seq_err_o` are registered and go high one cycle after the offending sample or commit.
- **Latency:**
  - Commit at `pc`=PHASE_OFFSET+3; FIFO write on the following edge.
  - `m_trig_tvalid` rises 2 clocks after the commit cycle when the FIFO was empty, i.e. at `pc`=(PHASE_OFFSET+5) mod 8.
- **Throughput:** at most one trigger per 8 clocks in; up to one per clock out.

## Test plan
- **Nominal stream.** Lock, then send 5 triggers (addr 0x100..0x104, meta 0x80..0x84) with `m_trig_tready`=1.
  - Expect 5 beats with tdata 0x80100..0x84104, each arriving 2 clocks after its window end.
  - Expect no error pulses and `err_count_o`=0.
- **Sequence gap.** Send meta 0x05 then 0x07.
  - Expect one `seq_err_o` pulse and `err_count_o`=1.
  - Both words are delivered; a following 0x08 raises no error.
- **Framing.**
  - Drop valid at the third window cycle: one `frame_err_o`, no beat.
  - Assert valid at `pc`=0: one `frame_err_o`, no beat.
- **Backpressure and overflow.** Hold `m_trig_tready`=0 and send 17 triggers.
  - Expect `overflow_o`=1 and 16 entries retained, with trigger 17 dropped.
  - Release ready: the 16 words drain in order, one per clock.
  - `clr_i` clears `overflow_o` and `err_count_o`.
- **Phase slip.** Deliver a phase pulse at `pc`=4 with a trigger pending.
  - Expect the trigger discarded, `err_count_o` incremented by 1, and `pc` resynced.
  - The next aligned trigger is captured normally.
- **Reset during operation.** Assert `sysclk_rst_i` with 3 entries queued.
  - All outputs return to their reset values immediately (asynchronous reset).
  - No beats are output until a new phase pulse and a new trigger arrive.
